// File: rtl/pool3_layer.sv
`default_nettype none
// ============================================================================
//  Module      : pool3_layer
//  Description : 2x2 / stride-2 signed max-pool stage behind conv3_layer.
//                Pools a channel-major W_IN x H_IN x C stream into an output
//                buffer, then replays the pooled frame downstream once the
//                consumer signals it can take a whole frame.
//  Revision    : 1.0  initial release
// ============================================================================
module pool3_layer #(
    parameter int W_IN  = 8,
    parameter int H_IN  = 8,
    parameter int C     = 64,
    parameter int DW    = 16,
    parameter int OB_AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] blob_din,
    input  logic          blob_din_en,
    input  logic          blob_din_eop,
    output logic          blob_din_rdy,
    output logic [DW-1:0] blob_dout,
    output logic          blob_dout_en,
    output logic          blob_dout_eop,
    input  logic          blob_dout_rdy
);

    localparam int c_XW    = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int c_YW    = (H_IN > 1) ? $clog2(H_IN) : 1;
    localparam int c_CW    = (C > 1) ? $clog2(C) : 1;
    localparam int c_CNTW  = OB_AW + 1;
    localparam int c_POOLS = C * (H_IN / 2) * (W_IN / 2);

    localparam logic [c_XW-1:0]   c_X_LAST = c_XW'(W_IN - 1);
    localparam logic [c_YW-1:0]   c_Y_LAST = c_YW'(H_IN - 1);
    localparam logic [c_CW-1:0]   c_C_LAST = c_CW'(C - 1);
    localparam logic [c_CNTW-1:0] c_WR_MAX = c_CNTW'(c_POOLS);
    localparam logic [c_CNTW-1:0] c_ONE    = c_CNTW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_WAIT_DS = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                 r_din_rdy;
    logic [c_XW-1:0]      r_x;
    logic [c_YW-1:0]      r_y;
    logic [c_CW-1:0]      r_ch;
    logic                 r_full;
    logic [c_CNTW-1:0]    r_wr_cnt;
    logic [c_CNTW-1:0]    w_wr_cnt_nxt;
    logic [c_CNTW-1:0]    r_rd_addr;
    logic signed [DW-1:0] r_hold;
    logic signed [DW-1:0] r_line [W_IN/2];
    logic [DW-1:0]        r_mem [2**OB_AW];

    logic signed [DW-1:0] w_din_s;
    logic signed [DW-1:0] w_line_q;
    logic signed [DW-1:0] w_hmax;
    logic signed [DW-1:0] w_vmax;
    logic                 w_accept;
    logic                 w_proc;
    logic                 w_write;
    logic                 w_rd_issue;
    logic                 w_rd_last;

    // rdy is registered so it reads 0 in reset and on the release edge
    assign blob_din_rdy = r_din_rdy;
    assign w_accept     = blob_din_en & r_din_rdy;
    // words beyond a full frame are swallowed until eop arrives
    assign w_proc       = w_accept & ~r_full;
    assign w_write      = w_proc & r_x[0] & r_y[0] & (r_wr_cnt != c_WR_MAX);

    // signed maxima; on a tie the earlier (held/line) word wins
    assign w_din_s  = blob_din;
    assign w_line_q = r_line[r_x[c_XW-1:1]];
    assign w_hmax   = (w_din_s > r_hold) ? w_din_s : r_hold;
    assign w_vmax   = (w_hmax > w_line_q) ? w_hmax : w_line_q;

    assign w_wr_cnt_nxt = w_write ? (r_wr_cnt + c_ONE) : r_wr_cnt;
    assign w_rd_issue   = (r_state == S_DRAIN) && (r_rd_addr != r_wr_cnt);
    assign w_rd_last    = w_rd_issue && ((r_rd_addr + c_ONE) == r_wr_cnt);

    // next-state: fill until eop, wait for downstream, drain, back to idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (w_accept) begin
                    if (blob_din_eop)
                        w_state_nxt = (w_wr_cnt_nxt == '0) ? S_IDLE : S_WAIT_DS;
                    else
                        w_state_nxt = S_FILL;
                end
            end
            S_WAIT_DS: if (blob_dout_rdy) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (r_rd_addr == r_wr_cnt) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // state register and input-ready flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_din_rdy <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_din_rdy <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FILL);
        end
    end

    // x/y/ch raster position of the incoming word; cleared at frame end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_ch   <= '0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            if (blob_din_eop) begin
                r_x    <= '0;
                r_y    <= '0;
                r_ch   <= '0;
                r_full <= 1'b0;
            end else if (!r_full) begin
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    if (r_y == c_Y_LAST) begin
                        r_y <= '0;
                        if (r_ch == c_C_LAST) begin
                            r_ch   <= '0;
                            r_full <= 1'b1;
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                    end else begin
                        r_y <= r_y + 1'b1;
                    end
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // first word of each horizontal pair
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_hold <= '0;
        else if (w_proc && !r_x[0])
            r_hold <= w_din_s;
    end

    // horizontal maxima of the even row, consumed by the following odd row
    always_ff @(posedge clk) begin
        if (w_proc && r_x[0] && !r_y[0])
            r_line[r_x[c_XW-1:1]] <= w_hmax;
    end

    // pooled-word count; cleared when the drain completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_wr_cnt <= '0;
        else if ((r_state == S_DRAIN) && (w_state_nxt == S_IDLE))
            r_wr_cnt <= '0;
        else
            r_wr_cnt <= w_wr_cnt_nxt;
    end

    // output buffer write port
    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_cnt[OB_AW-1:0]] <= w_vmax;
    end

    // read address walks 0..wr_cnt-1 while draining
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rd_addr <= '0;
        else if (r_state != S_DRAIN)
            r_rd_addr <= '0;
        else if (w_rd_issue)
            r_rd_addr <= r_rd_addr + c_ONE;
    end

    // registered read data with its valid and end-of-frame flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blob_dout     <= '0;
            blob_dout_en  <= 1'b0;
            blob_dout_eop <= 1'b0;
        end else begin
            blob_dout_en  <= w_rd_issue;
            blob_dout_eop <= w_rd_last;
            if (w_rd_issue)
                blob_dout <= r_mem[r_rd_addr[OB_AW-1:0]];
        end
    end

endmodule
`default_nettype wire
